// File: rtl/jt49_bus_arb.sv
// jt49_bus_arb -- two-port access arbiter/sequencer for the jt49 PSG register bus.
//
// A CPU port (p0) and a music-sequencer port (p1) share one PSG addr/din/cs_n/wr_n
// interface. Each accepted access becomes a single registered one-cycle cs_n strobe.
// PSG read data is captured the cycle after the strobe and returned as a one-cycle
// rvalid pulse on the port that issued the read.
//
// Reads of the envelope-shape register (0xD) can be served from a shadow copy
// (SHADOW_R13=1): any chip-select access to 0xD restarts the envelope, so such a
// read must not touch the PSG at all.
//
// Parameters
//   GAP         idle cycles after every access before the next grant (0..15)
//   FIXED_PRIO  0 = round-robin on a tie, 1 = port 0 always wins a tie
//   SHADOW_R13  1 = reads of 0xD come from the shadow copy, 0 = pass through
//
// Ports
//   clk, rst_n                    clock (posedge), synchronous active-low reset
//   pX_valid/pX_ready             request handshake, ready is combinational
//   pX_wr/pX_addr/pX_din          request fields, held stable while valid
//   pX_rvalid/pX_rdata            one-cycle read response, no back-pressure
//   psg_cs_n/psg_wr_n             registered PSG strobes
//   psg_addr/psg_din              registered PSG address / write data
//   psg_dout                      PSG read data, valid the cycle after the strobe
//   busy                          high whenever the sequencer is not idle

// Per-port read response register: a one-cycle rvalid pulse and the held rdata.
module jt49_bus_arb_rsp (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       rvalid_o,
  output logic [7:0] rdata_o
);
  logic       rvalid_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      rvalid_q <= load_i;
      if (load_i) rdata_q <= data_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
endmodule

module jt49_bus_arb #(
  parameter int GAP        = 0,
  parameter int FIXED_PRIO = 0,
  parameter int SHADOW_R13 = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  // port 0
  input  logic       p0_valid,
  output logic       p0_ready,
  input  logic       p0_wr,
  input  logic [3:0] p0_addr,
  input  logic [7:0] p0_din,
  output logic       p0_rvalid,
  output logic [7:0] p0_rdata,
  // port 1
  input  logic       p1_valid,
  output logic       p1_ready,
  input  logic       p1_wr,
  input  logic [3:0] p1_addr,
  input  logic [7:0] p1_din,
  output logic       p1_rvalid,
  output logic [7:0] p1_rdata,
  // PSG side
  output logic       psg_cs_n,
  output logic       psg_wr_n,
  output logic [3:0] psg_addr,
  output logic [7:0] psg_din,
  input  logic [7:0] psg_dout,
  output logic       busy
);

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] din;
  } req_t;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STROBE  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;

  localparam logic [3:0] GAP_CYC = 4'(GAP);
  localparam logic [3:0] R13     = 4'hD;

  logic [1:0]      state_q, state_d;
  logic [3:0]      gap_q, gap_d;
  logic            last_q, last_d;    // port granted most recently (round-robin pointer)
  logic            own_q, own_d;      // port owning the access in flight
  req_t            req_q, req_d, req_in;
  logic [7:0]      shadow_q, shadow_d;
  logic            cs_n_q, cs_n_d;
  logic            wr_n_q, wr_n_d;
  logic [3:0]      addr_q, addr_d;
  logic [7:0]      din_q, din_d;

  logic [1:0]      vld, rdy;
  logic            gnt, accept, done;
  logic            in_shadow, req_shadow;
  logic [1:0]      rsp_load;
  logic [7:0]      rsp_data;
  logic [1:0]      rvalid;
  logic [1:0][7:0] rdata;

  // ---------------------------------------------------------------------------
  // Grant: pick a port among the valid ones; only meaningful in IDLE.
  // ---------------------------------------------------------------------------
  assign vld = {p1_valid, p0_valid};

  always_comb begin
    if (vld == 2'b11) gnt = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    else              gnt = vld[1];
  end

  // Ready is held low during reset even though the state is already IDLE.
  assign rdy[0] = rst_n & (state_q == S_IDLE) & vld[0] & ~gnt;
  assign rdy[1] = rst_n & (state_q == S_IDLE) & vld[1] &  gnt;
  assign accept = |rdy;

  assign req_in = gnt ? {p1_wr, p1_addr, p1_din} : {p0_wr, p0_addr, p0_din};

  // A shadowed read never drives cs_n, so it has to be known at acceptance time.
  assign in_shadow  = (SHADOW_R13 != 0) && !req_in.wr && (req_in.addr == R13);
  assign req_shadow = (SHADOW_R13 != 0) && !req_q.wr  && (req_q.addr  == R13);

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE -> STROBE -> [CAPTURE] -> [GAP] -> IDLE
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    last_d   = last_q;
    own_d    = own_q;
    req_d    = req_q;
    shadow_d = shadow_q;
    // cs_n and wr_n fall back to 1 every cycle; only acceptance pulls them low.
    cs_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    addr_d   = addr_q;
    din_d    = din_q;
    rsp_load = 2'b00;
    rsp_data = psg_dout;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_STROBE;
          req_d   = req_in;
          own_d   = gnt;
          last_d  = gnt;
          // Strobe outputs are registered here so cs_n is low during STROBE.
          if (!in_shadow) begin
            cs_n_d = 1'b0;
            wr_n_d = ~req_in.wr;
            addr_d = req_in.addr;
            din_d  = req_in.din;
          end
        end
      end

      S_STROBE: begin
        if (req_q.wr && (req_q.addr == R13)) shadow_d = req_q.din;
        if (req_shadow) begin
          rsp_load[own_q] = 1'b1;
          rsp_data        = {4'h0, shadow_q[3:0]};
          done            = 1'b1;
        end else if (!req_q.wr) begin
          state_d = S_CAPTURE;
        end else begin
          done = 1'b1;
        end
      end

      S_CAPTURE: begin
        // psg_dout is the PSG's registered response to last cycle's strobe.
        rsp_load[own_q] = 1'b1;
        rsp_data        = psg_dout;
        done            = 1'b1;
      end

      default: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
    endcase

    // The counter is loaded with GAP-1 so the GAP state lasts exactly GAP cycles.
    if (done) begin
      if (GAP_CYC == 4'd0) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_GAP;
        gap_d   = GAP_CYC - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gap_q    <= 4'd0;
      last_q   <= 1'b1;   // port 0 wins the first tie
      own_q    <= 1'b0;
      req_q    <= '0;
      shadow_q <= 8'h00;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      addr_q   <= 4'h0;
      din_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      last_q   <= last_d;
      own_q    <= own_d;
      req_q    <= req_d;
      shadow_q <= shadow_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port response registers
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_port
    jt49_bus_arb_rsp u_rsp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (rsp_load[g]),
      .data_i   (rsp_data),
      .rvalid_o (rvalid[g]),
      .rdata_o  (rdata[g])
    );
  end

  assign p0_ready  = rdy[0];
  assign p1_ready  = rdy[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];

  assign psg_cs_n = cs_n_q;
  assign psg_wr_n = wr_n_q;
  assign psg_addr = addr_q;
  assign psg_din  = din_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_jt49_bus_arb.sv
// Bench for jt49_bus_arb. Instance 0: GAP=0, round-robin, shadowed 0xD.
// Instance 1: GAP=3, fixed priority, 0xD passed through. Each instance has a
// small PSG register-file stub answering reads one cycle after the strobe.
module tb_jt49_bus_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [1:0]      vld  [2];
  logic [1:0]      wr   [2];
  logic [1:0][3:0] addr [2];
  logic [1:0][7:0] din  [2];
  logic [1:0]      rdy  [2];
  logic [1:0]      rv   [2];
  logic [1:0][7:0] rdat [2];
  logic            cs_n [2];
  logic            wr_n [2];
  logic            busy [2];
  logic [3:0]      paddr[2];
  logic [7:0]      pdin [2];

  for (genvar i = 0; i < 2; i++) begin : g_dut
    logic       p0_rdy, p1_rdy, p0_rv, p1_rv, cs, wn, bz;
    logic [7:0] p0_rd, p1_rd, dout, pd;
    logic [3:0] pa;
    logic [7:0] regs [16];

    jt49_bus_arb #(
      .GAP        ((i == 0) ? 0 : 3),
      .FIXED_PRIO ((i == 0) ? 0 : 1),
      .SHADOW_R13 ((i == 0) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .p0_valid  (vld[i][0]),
      .p0_ready  (p0_rdy),
      .p0_wr     (wr[i][0]),
      .p0_addr   (addr[i][0]),
      .p0_din    (din[i][0]),
      .p0_rvalid (p0_rv),
      .p0_rdata  (p0_rd),
      .p1_valid  (vld[i][1]),
      .p1_ready  (p1_rdy),
      .p1_wr     (wr[i][1]),
      .p1_addr   (addr[i][1]),
      .p1_din    (din[i][1]),
      .p1_rvalid (p1_rv),
      .p1_rdata  (p1_rd),
      .psg_cs_n  (cs),
      .psg_wr_n  (wn),
      .psg_addr  (pa),
      .psg_din   (pd),
      .psg_dout  (dout),
      .busy      (bz)
    );

    // PSG stub: registered read data, valid the cycle after the strobe.
    always @(posedge clk) begin
      if (!cs) begin
        if (!wn) regs[pa] <= pd;
        else     dout <= regs[pa];
      end
    end

    assign rdy[i]   = {p1_rdy, p0_rdy};
    assign rv[i]    = {p1_rv, p0_rv};
    assign rdat[i]  = {p1_rd, p0_rd};
    assign cs_n[i]  = cs;
    assign wr_n[i]  = wn;
    assign busy[i]  = bz;
    assign paddr[i] = pa;
    assign pdin[i]  = pd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       port;
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    logic       strobe;   // access should reach the PSG
    int         lat;      // cycles from accept to rvalid, 0 = no rvalid
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [11];

  // One isolated transaction: request, wait for acceptance, then watch 4 cycles.
  task automatic txn(input int inst, input vec_t v);
    bit         got, other;
    int         p, rv_at;
    logic [7:0] rd;
    p = int'(v.port);
    @(posedge clk); #1;
    wr[inst][p] = v.w; addr[inst][p] = v.a; din[inst][p] = v.d; vld[inst][p] = 1'b1;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rdy[inst][p]) begin got = 1; break; end
    end
    chk("txn_accept", got, 1);
    @(posedge clk); #1 vld[inst][p] = 1'b0;
    rv_at = 0; rd = 8'h00; other = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("txn_cs_n", cs_n[inst], !v.strobe);
        if (v.strobe) begin
          chk("txn_wr_n", wr_n[inst], !v.w);
          chk("txn_addr", paddr[inst], v.a);
          if (v.w) chk("txn_din", pdin[inst], v.d);
        end else chk("txn_wr_n_idle", wr_n[inst], 1);
      end else begin
        chk("txn_cs_n_released", cs_n[inst], 1);
        chk("txn_wr_n_released", wr_n[inst], 1);
      end
      if (rv[inst][p] && rv_at == 0) begin rv_at = k; rd = rdat[inst][p]; end
      else if (rv[inst][p]) other = 1;
      if (rv[inst][1-p]) other = 1;
    end
    chk("txn_rvalid_latency", rv_at, v.lat);
    if (v.lat != 0) chk("txn_rdata", rd, v.exp);
    chk("txn_no_stray_rvalid", other, 0);
  endtask

  // random-phase stimulus
  task automatic new_req(input int p);
    int sel;
    sel = $urandom_range(0, 3);
    wr[0][p] = 1'($urandom_range(0, 1));
    case (sel)
      0:       addr[0][p] = 4'h0;
      1:       addr[0][p] = 4'h8;
      2:       addr[0][p] = 4'hD;
      default: addr[0][p] = 4'($urandom_range(0, 15));
    endcase
    din[0][p] = 8'($urandom);
    vld[0][p] = 1'b1;
  endtask

  logic gq [$];
  int   gcq[$];
  int   sq [$];
  int   busy_bad, rvbad;
  bit   got;
  vec_t v;

  // transaction-level reference model state
  int         free_at, last, gp, st_cyc, rv_cyc, rv_p;
  logic       st_w, rv_known;
  logic [3:0] st_a;
  logic [7:0] st_d, rv_d, shadow;
  logic [7:0] mreg [16];
  bit         known[16];
  logic [1:0] exp_rdy, acc_mask;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      vld[i] = 2'b00; wr[i] = 2'b00; addr[i] = '0; din[i] = '0;
    end
    // ---- reset state, with both ports of instance 0 requesting ----
    rst_n = 1'b0;
    wr[0] = 2'b11; addr[0][0] = 4'h1; addr[0][1] = 4'h2; din[0][0] = 8'h11; din[0][1] = 8'h22;
    vld[0] = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready_forced", rdy[0], 2'b00);
    chk("reset_cs_n", cs_n[0], 1);
    chk("reset_wr_n", wr_n[0], 1);
    chk("reset_addr", paddr[0], 0);
    chk("reset_din", pdin[0], 0);
    chk("reset_busy", busy[0], 0);
    chk("reset_rvalid", rv[0], 0);
    chk("reset_rdata", rdat[0], 0);
    chk("reset_busy_b", busy[1], 0);

    // ---- round-robin with both valid held ----
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < 30 && gq.size() < 6; n++) begin
      @(negedge clk);
      if (rdy[0] != 2'b00) begin
        chk("rr_onehot", rdy[0] == 2'b11, 0);
        gq.push_back(rdy[0][1]);
        gcq.push_back(n);
      end
    end
    @(posedge clk); #1 vld[0] = 2'b00;
    chk("rr_grant_count", gq.size(), 6);
    if (gq.size() == 6) begin
      chk("rr_first_grant_cycle", gcq[0], 0);
      for (int i = 0; i < 6; i++) chk("rr_order", gq[i], i % 2);
      for (int i = 1; i < 6; i++) chk("rr_spacing", gcq[i] - gcq[i-1], 2);
    end
    repeat (4) @(posedge clk);

    // ---- reset during CAPTURE of a read ----
    #1 wr[0][1] = 1'b0; addr[0][1] = 4'h0; vld[0][1] = 1'b1;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rdy[0][1]) begin got = 1; break; end
    end
    chk("capt_accept", got, 1);
    @(posedge clk); #1 vld[0][1] = 1'b0;                 // STROBE
    @(posedge clk); #1 rst_n = 1'b0;                     // CAPTURE
    wr[0] = 2'b11; addr[0][0] = 4'h1; addr[0][1] = 4'h2; vld[0] = 2'b11;
    @(negedge clk);
    chk("capt_ready_in_reset", rdy[0], 2'b00);
    chk("capt_busy_in_capture", busy[0], 1);
    @(posedge clk); #1 rst_n = 1'b1;
    rvbad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("post_reset_cs_n", cs_n[0], 1);
        chk("post_reset_busy", busy[0], 0);
        chk("post_reset_tie_port0", rdy[0], 2'b01);
      end
      if (rv[0] != 2'b00) rvbad++;
    end
    chk("aborted_read_no_rvalid", rvbad, 0);
    @(posedge clk); #1 vld[0] = 2'b00;
    repeat (4) @(posedge clk);

    // ---- table-driven single transactions on instance 0 ----
    tbl[0]  = '{1'b0, 1'b1, 4'h8, 8'h1F, 1'b1, 0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 4'h0, 8'hA5, 1'b1, 0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 3, 8'hA5};
    tbl[3]  = '{1'b0, 1'b0, 4'h8, 8'h00, 1'b1, 3, 8'h1F};
    tbl[4]  = '{1'b0, 1'b1, 4'hD, 8'h0B, 1'b1, 0, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 4'hD, 8'h00, 1'b0, 2, 8'h0B};
    tbl[6]  = '{1'b1, 1'b1, 4'hD, 8'h3C, 1'b1, 0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 4'hD, 8'h00, 1'b0, 2, 8'h0C};
    tbl[8]  = '{1'b1, 1'b1, 4'h8, 8'h7E, 1'b1, 0, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 4'h8, 8'h00, 1'b1, 3, 8'h7E};
    tbl[10] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 3, 8'hA5};
    for (int i = 0; i < 11; i++) txn(0, tbl[i]);

    // ---- instance 1: fixed priority, GAP=3 ----
    gq.delete(); gcq.delete(); sq.delete(); busy_bad = 0;
    @(posedge clk); #1;
    wr[1] = 2'b11; addr[1][0] = 4'h2; addr[1][1] = 4'h3; din[1][0] = 8'h33; din[1][1] = 8'h44;
    vld[1] = 2'b11;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!cs_n[1]) sq.push_back(n);
      if (rdy[1] != 2'b00) begin
        chk("prio_onehot", rdy[1] == 2'b11, 0);
        gq.push_back(rdy[1][1]);
        gcq.push_back(n);
        if (gq.size() == 3)      begin @(posedge clk); #1 vld[1][0] = 1'b0; end
        else if (gq.size() == 4) begin @(posedge clk); #1 vld[1][1] = 1'b0; end
      end else if (gq.size() > 0 && gq.size() < 4 && !busy[1]) busy_bad++;
    end
    chk("prio_grant_count", gq.size(), 4);
    chk("prio_strobe_count", sq.size(), 4);
    chk("prio_busy_between", busy_bad, 0);
    if (gq.size() == 4 && sq.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("prio_order", gq[i], (i == 3) ? 1 : 0);
      chk("prio_strobe_after_grant", sq[0] - gcq[0], 1);
      for (int i = 1; i < 4; i++) begin
        chk("prio_grant_spacing", gcq[i] - gcq[i-1], 5);
        chk("prio_strobe_spacing", sq[i] - sq[i-1], 5);
      end
    end
    v = '{1'b0, 1'b1, 4'hD, 8'h0B, 1'b1, 0, 8'h00};
    txn(1, v);
    v = '{1'b1, 1'b0, 4'hD, 8'h00, 1'b1, 3, 8'h0B};
    txn(1, v);

    // ---- randomized traffic on instance 0 against the reference model ----
    @(posedge clk); #1 rst_n = 1'b0; vld[0] = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    free_at = 0; last = 1; shadow = 8'h00; st_cyc = -1; rv_cyc = -1; rv_p = 0;
    st_w = 1'b0; st_a = 4'h0; st_d = 8'h00; rv_d = 8'h00; rv_known = 1'b0;
    for (int k = 0; k < 16; k++) begin known[k] = 0; mreg[k] = 8'h00; end
    acc_mask = 2'b00;
    for (int t = 0; t < 800; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (acc_mask[p]) vld[0][p] = 1'b0;
        if (!vld[0][p] && $urandom_range(0, 2) == 0) new_req(p);
      end
      @(negedge clk);
      // effects of earlier acceptances
      chk("rand_cs_n", cs_n[0], !(t == st_cyc));
      if (t == st_cyc) begin
        chk("rand_wr_n", wr_n[0], !st_w);
        chk("rand_addr", paddr[0], st_a);
        if (st_w) chk("rand_din", pdin[0], st_d);
      end else chk("rand_wr_n_idle", wr_n[0], 1);
      for (int p = 0; p < 2; p++) chk("rand_rvalid", rv[0][p], (t == rv_cyc) && (rv_p == p));
      if (t == rv_cyc && rv_known) chk("rand_rdata", rdat[0][rv_p], rv_d);
      // grant decision for this cycle
      exp_rdy = 2'b00;
      if (t >= free_at && vld[0] != 2'b00) begin
        if (vld[0] == 2'b11) gp = 1 - last;
        else                 gp = vld[0][1] ? 1 : 0;
        exp_rdy = (gp == 1) ? 2'b10 : 2'b01;
      end
      chk("rand_ready", rdy[0], exp_rdy);
      chk("rand_busy", busy[0], t < free_at);
      if (exp_rdy != 2'b00) begin
        last = gp;
        if (wr[0][gp]) begin
          st_cyc = t + 1; st_w = 1'b1; st_a = addr[0][gp]; st_d = din[0][gp];
          if (addr[0][gp] == 4'hD) shadow = din[0][gp];
          mreg[addr[0][gp]] = din[0][gp]; known[addr[0][gp]] = 1;
          free_at = t + 2;
        end else if (addr[0][gp] == 4'hD) begin
          rv_cyc = t + 2; rv_p = gp; rv_d = {4'h0, shadow[3:0]}; rv_known = 1'b1;
          free_at = t + 2;
        end else begin
          st_cyc = t + 1; st_w = 1'b0; st_a = addr[0][gp];
          rv_cyc = t + 3; rv_p = gp; rv_d = mreg[addr[0][gp]]; rv_known = known[addr[0][gp]];
          free_at = t + 3;
        end
      end
      acc_mask = rdy[0] & vld[0];
      @(posedge clk); #1;
    end
    vld[0] = 2'b00;
    repeat (6) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
